// File: rtl/icache.sv
// Direct-mapped, single-word-per-frame instruction cache in front of one bus controller lane.
// Hits are combinational; a miss issues one bus read and fills the frame when the lane is granted.
module icache #(
    parameter int unsigned SETS  = 16,
    parameter int unsigned IDX_W = $clog2(SETS)
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        iinv,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic [31:0] iload,
    input  logic        iwait
);

    localparam int unsigned TAG_W = 30 - IDX_W;

    typedef enum logic {
        IDLE,
        FETCH
    } state_t;

    state_t state;
    state_t state_next;

    logic [SETS-1:0]  valid;
    logic [TAG_W-1:0] tag_mem  [SETS];
    logic [31:0]      data_mem [SETS];

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             lookup_hit;
    logic             miss_start;
    logic             fill;

    // Word address of the outstanding miss; the fill targets this even if the core withdraws.
    logic [29:0]      held_addr;
    logic [IDX_W-1:0] held_idx;
    logic [TAG_W-1:0] held_tag;

    logic unused_byte_offset;

    assign unused_byte_offset = ^imemaddr[1:0];

    assign idx        = imemaddr[IDX_W+1:2];
    assign tag        = imemaddr[31:IDX_W+2];
    assign lookup_hit = valid[idx] && (tag_mem[idx] == tag);

    assign held_idx   = held_addr[IDX_W-1:0];
    assign held_tag   = held_addr[29:IDX_W];

    assign miss_start = (state == IDLE) && imemREN && !lookup_hit;
    assign fill       = (state == FETCH) && !iwait;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            held_addr <= '0;
        end else begin
            state <= state_next;
            if (miss_start) begin
                held_addr <= imemaddr[31:2];
            end
        end
    end

    // Invalidate takes priority over a simultaneous fill's valid bit.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid <= '0;
        end else if (iinv) begin
            valid <= '0;
        end else if (fill) begin
            valid[held_idx] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (fill) begin
            tag_mem[held_idx]  <= held_tag;
            data_mem[held_idx] <= iload;
        end
    end

    always_comb begin
        state_next = state;
        ihit       = 1'b0;
        imemload   = '0;
        iREN       = 1'b0;
        iaddr      = '0;
        unique case (state)
            IDLE: begin
                if (imemREN) begin
                    if (lookup_hit) begin
                        ihit     = 1'b1;
                        imemload = data_mem[idx];
                    end else begin
                        state_next = FETCH;
                    end
                end
            end
            FETCH: begin
                iREN  = 1'b1;
                iaddr = {held_addr, 2'b00};
                if (!iwait) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_icache.sv
// Randomized self-checking bench for icache against a per-index map of cached word addresses.
module tb_icache;

    logic        clk;
    logic        rst;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iinv;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;

    int unsigned n_checks;
    int unsigned n_pass;

    logic [31:0] mem [logic [29:0]];
    logic [29:0] cached [int];
    logic [25:0] tag_pool [4];

    icache #(.SETS(16), .IDX_W(4)) dut (
        .CLK      (clk),
        .RST      (rst),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .iinv     (iinv),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iload    (iload),
        .iwait    (iwait)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (!mem.exists(addr[31:2])) mem[addr[31:2]] = $urandom;
        return mem[addr[31:2]];
    endfunction

    function automatic bit model_hit(input logic [31:0] addr);
        int i;
        i = int'(addr[5:2]);
        return cached.exists(i) && (cached[i] == addr[31:2]);
    endfunction

    // One fetch: hit in cycle 0, or miss with w wait cycles then grant in cycle 1+w.
    task automatic fetch(input logic [31:0] addr, input int unsigned w,
                         input bit inv_at_fill, input bit drop);
        logic [31:0] waddr;
        bit          exp_hit;
        waddr = {addr[31:2], 2'b00};
        @(negedge clk);
        imemREN  = 1'b1;
        imemaddr = addr;
        iinv     = 1'b0;
        iwait    = 1'b1;
        #1;
        exp_hit = model_hit(addr);
        check("ihit_c0", {31'b0, ihit}, {31'b0, exp_hit});
        check("load_c0", imemload, exp_hit ? mem_word(addr) : 32'h0);
        check("iren_c0", {31'b0, iREN}, 32'h0);
        if (exp_hit) return;
        for (int unsigned c = 1; c <= w + 1; c++) begin
            @(negedge clk);
            if (drop && c == 2) imemREN = 1'b0;
            if (c == w + 1) begin
                iwait = 1'b0;
                iload = mem_word(addr);
                iinv  = inv_at_fill;
            end else begin
                iload = $urandom;
            end
            #1;
            check("iren_fetch", {31'b0, iREN}, 32'h1);
            check("iaddr_fetch", iaddr, waddr);
            check("ihit_fetch", {31'b0, ihit}, 32'h0);
        end
        if (inv_at_fill) cached.delete();
        else cached[int'(addr[5:2])] = addr[31:2];
        @(negedge clk);
        iwait   = 1'b1;
        iinv    = 1'b0;
        iload   = $urandom;
        imemREN = !drop && model_hit(addr);
        #1;
        check("iren_after", {31'b0, iREN}, 32'h0);
        check("ihit_after", {31'b0, ihit}, {31'b0, imemREN});
        check("load_after", imemload, imemREN ? mem_word(addr) : 32'h0);
    endtask

    task automatic inv_pulse();
        @(negedge clk);
        imemREN = 1'b0;
        iinv    = 1'b1;
        #1;
        check("ihit_inv", {31'b0, ihit}, 32'h0);
        @(negedge clk);
        iinv = 1'b0;
        cached.delete();
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        imemREN  = 1'b0;
        imemaddr = $urandom;
        #1;
        check("ihit_idle", {31'b0, ihit}, 32'h0);
        check("iren_idle", {31'b0, iREN}, 32'h0);
    endtask

    initial begin
        logic [31:0] a;
        n_checks = 0;
        n_pass   = 0;
        tag_pool = '{26'h0, 26'h1, 26'h3ff_ffff, 26'h155_5555};
        rst      = 1'b1;
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0040;
        iinv     = 1'b0;
        iload    = 32'hdead_beef;
        iwait    = 1'b0;
        #1;
        check("rst_ihit", {31'b0, ihit}, 32'h0);
        check("rst_iren", {31'b0, iREN}, 32'h0);
        check("rst_iaddr", iaddr, 32'h0);
        check("rst_load", imemload, 32'h0);
        repeat (2) @(negedge clk);
        rst     = 1'b0;
        imemREN = 1'b0;
        iwait   = 1'b1;

        // Cold miss then hit
        mem[30'h10] = 32'h2001_0005;
        fetch(32'h0000_0040, 3, 1'b0, 1'b0);
        fetch(32'h0000_0040, 0, 1'b0, 1'b0);

        // Conflict eviction at index 1
        fetch(32'h0000_0004, 1, 1'b0, 1'b0);
        fetch(32'h0000_0044, 2, 1'b0, 1'b0);
        fetch(32'h0000_0004, 0, 1'b0, 1'b0);

        // Invalidate in IDLE, then invalidate coinciding with grant
        for (int unsigned i = 0; i < 4; i++) fetch(32'h100 + 4 * i, i, 1'b0, 1'b0);
        inv_pulse();
        for (int unsigned i = 0; i < 4; i++) fetch(32'h100 + 4 * i, 0, 1'b0, 1'b0);
        fetch(32'h0000_0200, 2, 1'b1, 1'b0);
        fetch(32'h0000_0200, 1, 1'b0, 1'b0);

        // Request withdrawn one cycle into the miss
        fetch(32'h0000_0300, 5, 1'b0, 1'b1);
        fetch(32'h0000_0300, 0, 1'b0, 1'b0);

        // Asynchronous reset mid-miss
        @(negedge clk);
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0400;
        iwait    = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("iren_pre_rst", {31'b0, iREN}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("iren_rst", {31'b0, iREN}, 32'h0);
        check("ihit_rst", {31'b0, ihit}, 32'h0);
        check("load_rst", imemload, 32'h0);
        cached.delete();
        @(negedge clk);
        rst     = 1'b0;
        imemREN = 1'b0;
        fetch(32'h0000_0400, 1, 1'b0, 1'b0);
        fetch(32'h0000_0040, 0, 1'b0, 1'b0);

        // Byte offset ignored
        fetch(32'h0000_0080, 2, 1'b0, 1'b0);
        fetch(32'h0000_0083, 0, 1'b0, 1'b0);

        for (int unsigned n = 0; n < 300; n++) begin
            int unsigned r;
            r = $urandom_range(0, 9);
            a = {tag_pool[$urandom_range(0, 3)], 4'($urandom_range(0, 15)),
                 2'($urandom_range(0, 3))};
            if (r == 0) inv_pulse();
            else if (r == 1) idle_cycle();
            else fetch(a, $urandom_range(0, 4), ($urandom_range(0, 9) == 0), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/icache.md
# icache

Per-core direct-mapped instruction cache sitting directly upstream of the instruction bus controller. It serves the core's fetch stage with hits in the same cycle and forwards misses as a single-word read on that core's request lane (`iREN`/`iaddr` into the bus controller). It then consumes the arbitrated `iload`/`iwait` returned for that lane. One instance per core; instance N connects to lane N of the bus controller.

## Interface
- `SETS`, 16, number of frames; power of two, ≥2.
- `IDX_W`, log2(SETS) = 4, index width; tag width is 30 − IDX_W.
- `CLK`  in  1  single clock; all state updates on rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `imemREN`  in  1  core fetch request.
- `imemaddr`  in  32  core fetch byte address; bits [1:0] ignored.
- `ihit`  out  1  `imemload` valid for the current `imemaddr` this cycle.
- `imemload`  out  32  instruction word.
- `iinv`  in  1  invalidate-all pulse (flush/halt path).
- `iREN`  out  1  bus read request to the bus controller lane.
- `iaddr`  out  32  bus read word address, bits [1:0] = 0.
- `iload`  in  32  bus read data, valid when `iwait` = 0 while `iREN` = 1.
- `iwait`  in  1  bus busy / lane not yet granted.

## Operation
- Address split: index = `imemaddr`[IDX_W+1:2], tag = `imemaddr`[31:IDX_W+2].
- Each frame holds valid bit, tag, and one 32-bit data word.
- State machine with two states, IDLE and FETCH. Reset state is IDLE.
- IDLE:
  - `ihit` = `imemREN` & valid[idx] & (tag[idx] == addr tag), combinational.
  - `imemload` = data[idx] whenever `ihit`; otherwise 0.
  - `iREN` = 0 and `iaddr` = 0.
  - If `imemREN` and no hit, go to FETCH. Otherwise stay in IDLE.
- FETCH:
  - `iREN` = 1 and `iaddr` = {`imemaddr`[31:2], 2'b00}; `ihit` = 0.
  - While `iwait` = 1, hold.
  - When `iwait` = 0: write frame[idx] with valid = 1, tag, and data = `iload`, then go to IDLE.
- The core holds `imemaddr` stable until `ihit`.
- If `imemREN` drops during FETCH, the fill still completes; the bus transaction is never aborted. The cache then returns to IDLE.
- `iinv` = 1 clears all valid bits at the next edge, in any state.
- If `iinv` and fill completion occur in the same cycle, invalidate wins: the frame's tag and data are written, but its valid bit is 0.
- Conflict misses replace the frame unconditionally. No write path exists; instruction memory is read-only from this block.
- Reset: all valid bits 0 and state IDLE. Tag and data arrays need not be reset. All outputs are 0 while `RST` is high.

## Timing
- Hit latency: 0 cycles; `ihit` is asserted in the same cycle `imemREN`/`imemaddr` are presented.
- Miss, with the request presented in cycle 0:
  - cycle 0: `ihit` = 0, FETCH entered at the edge.
  - cycle 1 onward: `iREN` = 1.
  - With W cycles of `iwait` = 1 followed by one cycle of `iwait` = 0 in cycle 1+W, the frame fills at that edge.
  - `ihit` = 1 in cycle 2+W. Miss penalty = W + 2 cycles.
- `iREN` and `iaddr` are registered-state outputs, decoded from the state register and held address. They are glitch-free with respect to `iwait`.
- `iREN` deasserts in the cycle after `iwait` = 0 is seen; there are no back-to-back bus requests without a pass through IDLE.
- Asynchronous `RST` mid-FETCH: `iREN` drops immediately and no frame is written.

## Test plan
- Cold miss then hit:
  - Stimulus: after reset, `imemREN` = 1, `imemaddr` = 0x0000_0040; bus returns `iload` = 0x2001_0005 with W = 3.
  - Required: `iREN` = 1 with `iaddr` = 0x40 for 4 cycles; `ihit` = 1 and `imemload` = 0x2001_0005 exactly 5 cycles after the request.
  - A repeat fetch of 0x40 hits in 0 cycles.
- Conflict eviction:
  - Stimulus: fill 0x0000_0004, then fetch 0x0000_0044 (same index 1, different tag).
  - Required: miss and fill; a subsequent fetch of 0x04 misses again.
- Invalidate:
  - Stimulus: fill 4 distinct indices, pulse `iinv` for one cycle in IDLE.
  - Required: all 4 addresses miss afterward.
  - Stimulus: `iinv` on the same cycle as `iwait` falling.
  - Required: the filled address still misses on the next fetch.
- Request withdrawn:
  - Stimulus: `imemREN` drops 1 cycle into FETCH, W = 5.
  - Required: `iREN` is held through the grant, the frame fills, and the block returns to IDLE with `ihit` = 0 and `iREN` = 0.
- Reset mid-miss:
  - Stimulus: assert `RST` asynchronously during FETCH.
  - Required: `iREN`, `ihit`, and `imemload` go to 0 immediately; after release, the prior address misses.
- Byte offset ignored:
  - Stimulus: fill 0x0000_0080, then fetch 0x0000_0083.
  - Required: hit in 0 cycles with the same data.
